// File: rtl/mem_filter.sv
// rtl/mem_filter.sv - first-order IIR low-pass whose coefficient is fetched from external byte RAM
// Define MEM_FILTER_HISTORY_EN to log every output sample into a RAM ring buffer.
module mem_filter #(
  parameter int          SAMPLE_DIV = 256,
  parameter logic [15:0] COEF_ADDR  = 16'h0000,
  parameter logic [15:0] HIST_BASE  = 16'h0100,
  parameter int          HIST_DEPTH = 64
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic signed [23:0] WaveIn,
  output logic signed [23:0] WaveOut,
  output logic [15:0]        MemAddr,
  inout  wire  [7:0]         MemData,
  output logic               MemClk,
  output logic               MemWrite
);

  localparam int CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RD_SETUP = 3'd1;
  localparam logic [2:0] S_RD_CLK   = 3'd2;
  localparam logic [2:0] S_RD_CAP   = 3'd3;
  localparam logic [2:0] S_COMPUTE  = 3'd4;
`ifdef MEM_FILTER_HISTORY_EN
  localparam logic [2:0] S_WR_SETUP = 3'd5;
  localparam logic [2:0] S_WR_CLK   = 3'd6;
  localparam logic [2:0] S_WR_END   = 3'd7;
  localparam int         PTR_W      = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;
`endif

  logic [CNT_W-1:0]   cnt;
  logic               tick;
  logic [2:0]         state;
  logic signed [23:0] x;
  logic signed [23:0] y;
  logic signed [23:0] y_next;
  logic [7:0]         alpha;
  logic signed [24:0] diff;
  logic signed [33:0] prod;

  assign tick = (cnt == CNT_W'(SAMPLE_DIV - 1));

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // alpha is zero-extended so the product stays signed; >>> 8 floors toward -inf.
  always_comb begin
    diff   = {x[23], x} - {y[23], y};
    prod   = 34'(diff) * 34'($signed({1'b0, alpha}));
    y_next = y + 24'(prod >>> 8);
  end

`ifdef MEM_FILTER_HISTORY_EN
  logic [PTR_W-1:0] ptr;
  logic [1:0]       bidx;
  logic [7:0]       wdata;
  logic [7:0]       y_byte;
  logic [15:0]      hist_addr;

  assign hist_addr = HIST_BASE + 16'(ptr) * 16'd3 + 16'(bidx);

  always_comb begin
    case (bidx)
      2'd0:    y_byte = y[7:0];
      2'd1:    y_byte = y[15:8];
      default: y_byte = y[23:16];
    endcase
  end

  // The bus is only ever driven while a write is in progress.
  assign MemData = MemWrite ? wdata : 8'bz;
`else
  logic unused_hist;

  assign unused_hist = ^{HIST_BASE, HIST_DEPTH};
  assign MemWrite    = 1'b0;
  assign MemData     = 8'bz;
`endif

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state   <= S_IDLE;
      x       <= '0;
      y       <= '0;
      alpha   <= '0;
      WaveOut <= '0;
      MemAddr <= '0;
      MemClk  <= 1'b0;
`ifdef MEM_FILTER_HISTORY_EN
      MemWrite <= 1'b0;
      ptr      <= '0;
      bidx     <= '0;
      wdata    <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (tick) begin
            x       <= WaveIn;
            MemAddr <= COEF_ADDR;
`ifdef MEM_FILTER_HISTORY_EN
            MemWrite <= 1'b0;
`endif
            state   <= S_RD_SETUP;
          end
        end
        S_RD_SETUP: begin
          MemClk <= 1'b1;
          state  <= S_RD_CLK;
        end
        S_RD_CLK: begin
          MemClk <= 1'b0;
          state  <= S_RD_CAP;
        end
        S_RD_CAP: begin
          alpha <= MemData;
          state <= S_COMPUTE;
        end
        S_COMPUTE: begin
          y       <= y_next;
          WaveOut <= y_next;
`ifdef MEM_FILTER_HISTORY_EN
          bidx    <= 2'd0;
          state   <= S_WR_SETUP;
`else
          state   <= S_IDLE;
`endif
        end
`ifdef MEM_FILTER_HISTORY_EN
        S_WR_SETUP: begin
          MemAddr  <= hist_addr;
          wdata    <= y_byte;
          MemWrite <= 1'b1;
          state    <= S_WR_CLK;
        end
        S_WR_CLK: begin
          MemClk <= 1'b1;
          state  <= S_WR_END;
        end
        S_WR_END: begin
          MemClk <= 1'b0;
          if (bidx == 2'd2) begin
            MemWrite <= 1'b0;
            ptr      <= (ptr == PTR_W'(HIST_DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
            state    <= S_IDLE;
          end else begin
            bidx  <= bidx + 2'd1;
            state <= S_WR_SETUP;
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_filter.sv
// tb/tb_mem_filter.sv - directed self-checking bench for mem_filter with a behavioural byte RAM
module tb_mem_filter;

  localparam int SD = 32;

  logic               Clock = 1'b0;
  logic               Reset = 1'b1;
  logic signed [23:0] WaveIn = '0;
  logic signed [23:0] WaveOut;
  logic [15:0]        MemAddr;
  wire  [7:0]         MemData;
  logic               MemClk;
  logic               MemWrite;

  logic [7:0]  ram [0:65535];
  logic [7:0]  rd = '0;
  logic        ram_oe = 1'b1;
  logic        probe_en = 1'b0;
  logic [7:0]  probe_val = '0;
  logic        bd_we = 1'b0;
  logic [15:0] bd_addr = '0;
  logic [7:0]  bd_data = '0;
  logic        saw_write = 1'b0;
  int          compared = 0;
  int          mismatched = 0;

  mem_filter #(.SAMPLE_DIV(SD)) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .WaveIn  (WaveIn),
    .WaveOut (WaveOut),
    .MemAddr (MemAddr),
    .MemData (MemData),
    .MemClk  (MemClk),
    .MemWrite(MemWrite)
  );

  always #5 Clock = ~Clock;

  // RAM model: write or latch on MemClk rise; bd_we is a bench-side backdoor write.
  always @(posedge MemClk or posedge bd_we) begin
    if (bd_we) ram[bd_addr] <= bd_data;
    else if (MemWrite) ram[MemAddr] <= MemData;
    else rd <= ram[MemAddr];
  end

  assign MemData = (!MemWrite && (ram_oe || probe_en)) ? (probe_en ? probe_val : rd) : 8'bz;

  always @(posedge Clock) if (MemWrite === 1'b1) saw_write <= 1'b1;

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    bd_addr = a; bd_data = d; bd_we = 1'b1;
    #1 bd_we = 1'b0;
    #1;
  endtask

  task automatic hold_reset();
    @(negedge Clock);
    Reset = 1'b1;
  endtask

  task automatic release_reset();
    @(negedge Clock);
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    for (int a = 16'h0100; a <= 16'h01C0; a++) poke(16'(a), 8'hAA);
    @(negedge Clock);
    compared++; if (WaveOut !== 24'h0) begin mismatched++; $display("FAIL reset_waveout: got %h expected 000000", WaveOut); end
    compared++; if (MemAddr !== 16'h0) begin mismatched++; $display("FAIL reset_memaddr: got %h expected 0000", MemAddr); end
    compared++; if (MemClk !== 1'b0) begin mismatched++; $display("FAIL reset_memclk: got %b expected 0", MemClk); end
    compared++; if (MemWrite !== 1'b0) begin mismatched++; $display("FAIL reset_memwrite: got %b expected 0", MemWrite); end
  endtask

  task automatic test_basic();
    logic [7:0] e [0:5];
    e = '{8'h00, 8'h00, 8'h18, 8'h00, 8'h00, 8'h24};
    poke(16'h0000, 8'h80);
    WaveIn = 24'h300000;
    release_reset();
    repeat (SD + 3) @(posedge Clock);
    #1;
    compared++; if (WaveOut !== 24'h0) begin mismatched++; $display("FAIL latency_early: got %h expected 000000", WaveOut); end
    @(posedge Clock);
    #1;
    compared++; if (WaveOut !== 24'h180000) begin mismatched++; $display("FAIL basic_first: got %h expected 180000", WaveOut); end
    repeat (SD) @(posedge Clock);
    #1;
    compared++; if (WaveOut !== 24'h240000) begin mismatched++; $display("FAIL basic_second: got %h expected 240000", WaveOut); end
`ifdef MEM_FILTER_HISTORY_EN
    repeat (12) @(posedge Clock);
    #1;
    for (int i = 0; i < 6; i++) begin
      compared++;
      if (ram[16'(256 + i)] !== e[i]) begin mismatched++; $display("FAIL hist_byte_%0d: got %h expected %h", i, ram[16'(256 + i)], e[i]); end
    end
`endif
  endtask

  task automatic test_negative();
    hold_reset();
    poke(16'h0000, 8'h80);
    WaveIn = 24'hCFFFFF;
    release_reset();
    repeat (SD + 4) @(posedge Clock);
    #1;
    compared++; if (WaveOut !== 24'hE7FFFF) begin mismatched++; $display("FAIL negative_floor: got %h expected e7ffff", WaveOut); end
  endtask

  task automatic test_alpha_zero();
    hold_reset();
    poke(16'h0000, 8'h00);
    WaveIn = 24'h123456;
    release_reset();
    repeat (SD + 4) @(posedge Clock);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) repeat (SD) @(posedge Clock);
      #1;
      compared++; if (WaveOut !== 24'h0) begin mismatched++; $display("FAIL alpha_zero_%0d: got %h expected 000000", i, WaveOut); end
      WaveIn = (i == 0) ? 24'hCFFFFF : 24'h7FFFFF;
    end
  endtask

  task automatic test_alpha_ff();
    hold_reset();
    poke(16'h0000, 8'hFF);
    WaveIn = 24'h300000;
    release_reset();
    repeat (SD + 4) @(posedge Clock);
    #1;
    compared++; if (WaveOut !== 24'h2FD000) begin mismatched++; $display("FAIL alpha_ff: got %h expected 2fd000", WaveOut); end
  endtask

  task automatic test_square();
    logic signed [23:0] e [0:4];
    logic signed [23:0] prev;
    e = '{24'h060000, 24'h0B4000, 24'h0FD800, 24'h13DD00, 24'h0B615F};
    hold_reset();
    poke(16'h0000, 8'h20);
    WaveIn = 24'h300000;
    release_reset();
    repeat (SD + 4) @(posedge Clock);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) repeat (SD) @(posedge Clock);
      #1;
      compared++; if (WaveOut !== e[i]) begin mismatched++; $display("FAIL square_step_%0d: got %h expected %h", i, WaveOut, e[i]); end
      if (i == 3) WaveIn = 24'hCFFFFF;
    end
    prev = e[4];
    for (int i = 0; i < 5; i++) begin
      repeat (SD) @(posedge Clock);
      #1;
      compared++;
      if (!(WaveOut < prev && WaveOut >= 24'shCFFFFF)) begin mismatched++; $display("FAIL square_fall_%0d: got %h expected below %h and not below cfffff", i, WaveOut, prev); end
      prev = WaveOut;
    end
    WaveIn = 24'h300000;
    for (int i = 0; i < 6; i++) begin
      repeat (SD) @(posedge Clock);
      #1;
      compared++;
      if (!(WaveOut > prev && WaveOut <= 24'sh300000)) begin mismatched++; $display("FAIL square_rise_%0d: got %h expected above %h and not above 300000", i, WaveOut, prev); end
      prev = WaveOut;
    end
  endtask

  task automatic test_bus_idle();
    hold_reset();
    poke(16'h0000, 8'h80);
    WaveIn = 24'h300000;
    release_reset();
    repeat (SD + 4) @(posedge Clock);
`ifdef MEM_FILTER_HISTORY_EN
    repeat (8) @(posedge Clock);
    #1;
    compared++; if (MemWrite !== 1'b1 || MemAddr !== 16'h0102 || MemData !== 8'h18) begin
      mismatched++; $display("FAIL write_bus: got we=%b addr=%h data=%h expected we=1 addr=0102 data=18", MemWrite, MemAddr, MemData);
    end
    repeat (4) @(posedge Clock);
`else
    repeat (12) @(posedge Clock);
`endif
    ram_oe = 1'b0;
    probe_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge Clock);
      probe_val = i[0] ? 8'h5A : 8'hA5;
      #1;
      compared++; if (MemWrite !== 1'b0 || MemData !== probe_val) begin
        mismatched++; $display("FAIL bus_release_%0d: got we=%b data=%h expected we=0 data=%h", i, MemWrite, MemData, probe_val);
      end
    end
    probe_en = 1'b0;
    ram_oe = 1'b1;
  endtask

`ifdef MEM_FILTER_HISTORY_EN
  task automatic test_history_wrap();
    logic [7:0] e [0:3];
    e = '{8'h00, 8'h00, 8'h18, 8'h00};
    hold_reset();
    for (int a = 16'h0100; a <= 16'h01C0; a++) poke(16'(a), 8'hAA);
    poke(16'h0000, 8'h00);
    WaveIn = 24'h123456;
    release_reset();
    repeat (SD + 4) @(posedge Clock);
    for (int i = 1; i < 64; i++) repeat (SD) @(posedge Clock);
    repeat (12) @(posedge Clock);
    compared++; if (ram[16'h01BD] !== 8'h00 || ram[16'h01BF] !== 8'h00) begin mismatched++; $display("FAIL wrap_slot63: got %h %h expected 00 00", ram[16'h01BD], ram[16'h01BF]); end
    compared++; if (ram[16'h01C0] !== 8'hAA) begin mismatched++; $display("FAIL wrap_beyond: got %h expected aa", ram[16'h01C0]); end
    poke(16'h0000, 8'h80);
    poke(16'h0100, 8'h55);
    poke(16'h0101, 8'h55);
    poke(16'h0102, 8'h55);
    WaveIn = 24'h300000;
    repeat (SD - 12) @(posedge Clock);
    #1;
    compared++; if (WaveOut !== 24'h180000) begin mismatched++; $display("FAIL wrap_sample65: got %h expected 180000", WaveOut); end
    repeat (12) @(posedge Clock);
    #1;
    for (int i = 0; i < 4; i++) begin
      compared++;
      if (ram[16'(256 + i)] !== e[i]) begin mismatched++; $display("FAIL wrap_byte_%0d: got %h expected %h", i, ram[16'(256 + i)], e[i]); end
    end
  endtask
`endif

  task automatic test_reset_midrun();
    hold_reset();
    for (int a = 16'h0100; a <= 16'h0102; a++) poke(16'(a), 8'hAA);
    poke(16'h0000, 8'h80);
    WaveIn = 24'h300000;
    release_reset();
    repeat (SD + 4) @(posedge Clock);
    repeat (4) @(posedge Clock);
    #2;
`ifdef MEM_FILTER_HISTORY_EN
    compared++; if (MemWrite !== 1'b1 || MemAddr !== 16'h0101) begin mismatched++; $display("FAIL midrun_state: got we=%b addr=%h expected we=1 addr=0101", MemWrite, MemAddr); end
`endif
    Reset = 1'b1;
    #1;
    compared++; if (WaveOut !== 24'h0 || MemAddr !== 16'h0 || MemClk !== 1'b0 || MemWrite !== 1'b0) begin
      mismatched++; $display("FAIL midrun_async: got out=%h addr=%h clk=%b we=%b expected all zero", WaveOut, MemAddr, MemClk, MemWrite);
    end
`ifdef MEM_FILTER_HISTORY_EN
    compared++; if (ram[16'h0100] !== 8'h00 || ram[16'h0101] !== 8'hAA) begin
      mismatched++; $display("FAIL midrun_partial: got %h %h expected 00 aa", ram[16'h0100], ram[16'h0101]);
    end
    for (int a = 16'h0100; a <= 16'h0102; a++) poke(16'(a), 8'hAA);
`endif
    release_reset();
    repeat (SD + 4) @(posedge Clock);
    #1;
    compared++; if (WaveOut !== 24'h180000) begin mismatched++; $display("FAIL midrun_restart: got %h expected 180000", WaveOut); end
`ifdef MEM_FILTER_HISTORY_EN
    repeat (12) @(posedge Clock);
    #1;
    compared++; if (ram[16'h0100] !== 8'h00 || ram[16'h0101] !== 8'h00 || ram[16'h0102] !== 8'h18) begin
      mismatched++; $display("FAIL midrun_ptr0: got %h %h %h expected 00 00 18", ram[16'h0100], ram[16'h0101], ram[16'h0102]);
    end
`endif
  endtask

  task automatic test_write_activity();
`ifdef MEM_FILTER_HISTORY_EN
    compared++; if (saw_write !== 1'b1) begin mismatched++; $display("FAIL write_seen: got %b expected 1", saw_write); end
`else
    compared++; if (saw_write !== 1'b0) begin mismatched++; $display("FAIL no_write: got %b expected 0", saw_write); end
    compared++; if (ram[16'h0100] !== 8'hAA) begin mismatched++; $display("FAIL no_history: got %h expected aa", ram[16'h0100]); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_alpha_zero();
    test_alpha_ff();
    test_square();
    test_bus_idle();
`ifdef MEM_FILTER_HISTORY_EN
    test_history_wrap();
`endif
    test_reset_midrun();
    test_write_activity();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
